counter_updn: RTL and testbench
===============================

Name: counter_updn

Overview:
- 8-bit synchronous up/down counter with a programmable step size, a synchronous parallel preload and a count enable.
- General-purpose timing/sequencing block driven from a single clock domain.
- The counter register drives the output directly; there is no output logic after the register.

Parameters:
- CNT_W, 8, width of the count register and of cout.
- PL_W, 4, width of pl_data. pl_data is zero-extended to CNT_W on preload.
- INC_W, 4, width of incr, the step size. It is zero-extended to CNT_W before the add or subtract.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears the counter.
- enable  input  1  count enable; when 1, the counter steps on each clock edge.
- updn  input  1  count direction; 1 = up (add incr), 0 = down (subtract incr).
- preload  input  1  synchronous load strobe; loads pl_data on the next rising edge.
- pl_data  input  PL_W  preload value.
- incr  input  INC_W  step magnitude, unsigned, 0..15.
- cout  output  CNT_W  current count; registered.

Behaviour:
- Reset:
  - reset=1 forces cout=0 immediately, without waiting for a clock edge, and holds it at 0 while reset is asserted.
  - The first update happens on the first rising edge after reset deasserts.
  - Reset mid-operation abandons the count. No other state exists.
- Priority on each rising edge, highest first: reset, then preload, then enable, otherwise hold.
- preload=1:
  - cout <= {zero, pl_data}. Loads regardless of enable and updn; incr is ignored that cycle.
  - The loaded value is visible 1 cycle later. Stepping resumes on the following edge if enable=1.
- preload=0 and enable=1:
  - updn=1: cout <= (cout + incr) mod 2^CNT_W.
  - updn=0: cout <= (cout - incr) mod 2^CNT_W.
- preload=0 and enable=0: cout holds its value.
- incr=0 with enable=1: cout holds; this is legal.
- Wrap-around: modulo arithmetic with no saturation, carry/borrow output or sticky flag.
  - Example: 252 + 4 = 0.
  - Example: 2 - 4 = 254.
- Input sampling:
  - All control inputs and incr are sampled at the rising edge.
  - A change to incr or updn takes effect on the next edge.
- Latency: 1 clock from an input change to the cout update. No handshake; every cycle is accepted.
- Implementation: no combinational path from any input to cout. The step adder is a single CNT_W-bit add/subtract selected by updn.

Decomposition:
- Shared package counter_pkg:
  - Localparams CNT_W, PL_W and INC_W.
  - A typedef for the count type, cnt_t of CNT_W bits.
- Optional sub-module counter_step: purely combinational next-value logic.
  - Inputs: cur, incr, updn, enable, preload, pl_data.
  - Output: nxt.
- The top level holds only the asynchronous-reset register.

Test Plan:
- Reset and count up: reset=1 for 3 edges, with enable=1, updn=1, incr=1.
  - cout=0 throughout reset.
  - Deassert reset; after 26 edges cout=26.
- Preload: pulse preload for 1 edge with pl_data=5 while counting up by 1.
  - cout=5 after that edge; 10 edges later cout=15.
  - Then preload pl_data=2: cout=2, then 12 after 10 more edges.
- Enable hold: enable=0 for 10 edges at cout=12.
  - cout stays 12.
  - Re-enable with incr=4: cout steps 16, 20, 24, ...
- Up wrap: from cout=252 with updn=1, incr=4 → next value 0.
- Down count and wrap: updn=0, incr=4 from cout=6 → 2, then 254, then 250.
- Asynchronous reset and priority:
  - reset asserted between edges clears cout without a clock edge.
  - preload=1 together with enable=1, updn=0 loads pl_data and does not decrement.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared widths and count type for the up/down counter.
package counter_pkg;

  localparam int CNT_W = 8;
  localparam int PL_W  = 4;
  localparam int INC_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/counter_updn_if.sv
// Control and count bus of the up/down counter.
// The master drives the controls; the slave is the counter.
interface counter_updn_if;
  import counter_pkg::*;

  logic              enable;
  logic              updn;
  logic              preload;
  logic [PL_W-1:0]   pl_data;
  logic [INC_W-1:0]  incr;
  cnt_t              cout;

  modport master (
    output enable, updn, preload, pl_data, incr,
    input  cout
  );

  modport slave (
    input  enable, updn, preload, pl_data, incr,
    output cout
  );

endinterface

// File: rtl/counter_step.sv
// Combinational next-count logic: preload beats enable, enable steps
// up or down by incr with modulo wrap, otherwise hold.
module counter_step
  import counter_pkg::*;
(
  input  cnt_t             cur,
  input  logic [INC_W-1:0] incr,
  input  logic             updn,
  input  logic             enable,
  input  logic             preload,
  input  logic [PL_W-1:0]  pl_data,
  output cnt_t             nxt
);

  cnt_t step;
  cnt_t stepped;
  cnt_t loaded;

  assign step   = {{(CNT_W-INC_W){1'b0}}, incr};
  assign loaded = {{(CNT_W-PL_W){1'b0}}, pl_data};

  // Single add/subtract; overflow bits drop off, giving wrap-around.
  always_comb begin
    stepped = cur;
    if (updn) stepped = cur + step;
    else      stepped = cur - step;
  end

  // Priority select of the next count.
  always_comb begin
    nxt = cur;
    if (preload)     nxt = loaded;
    else if (enable) nxt = stepped;
  end

endmodule

// File: rtl/counter_updn.sv
// 8-bit up/down counter with programmable step, preload and enable.
// The count register drives cout directly.
module counter_updn
  import counter_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  counter_updn_if.slave  bus
);

  cnt_t cnt;
  cnt_t cnt_next;

  counter_step u_step (
    .cur     (cnt),
    .incr    (bus.incr),
    .updn    (bus.updn),
    .enable  (bus.enable),
    .preload (bus.preload),
    .pl_data (bus.pl_data),
    .nxt     (cnt_next)
  );

  // Count register with immediate clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_next;
  end

  assign bus.cout = cnt;

endmodule

// File: tb/tb_counter_updn.sv
// Self-checking bench for counter_updn: directed test plan then random
// stimulus against an arithmetic reference model.
module tb_counter_updn;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   model;
  int   total  = 0;
  int   passed = 0;

  counter_updn_if bus ();

  counter_updn dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: cout=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive(input bit en, input bit ud, input bit pl,
                       input int pd, input int inc);
    bus.enable  = en;
    bus.updn    = ud;
    bus.preload = pl;
    bus.pl_data = pd[PL_W-1:0];
    bus.incr    = inc[INC_W-1:0];
  endtask

  // One clock: apply the counter rules to the values present at the edge.
  task automatic step(input string tag);
    int pd, inc;
    @(posedge clk);
    pd  = int'(bus.pl_data);
    inc = int'(bus.incr);
    if (reset)            model = 0;
    else if (bus.preload) model = pd;
    else if (bus.enable)  model = bus.updn ? (model + inc) % 256
                                           : (model - inc + 256) % 256;
    #1;
    $display("t=%0t %s rst=%0b en=%0b ud=%0b pl=%0b pd=%0d inc=%0d cout=%0d exp=%0d",
             $time, tag, reset, bus.enable, bus.updn, bus.preload, pd, inc,
             bus.cout, model);
    check(tag, int'(bus.cout), model);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    model = 0;
    reset = 1'b1;
    drive(1, 1, 0, 0, 1);

    // Reset held for 3 edges while enabled.
    #1 check("reset_async", int'(bus.cout), 0);
    steps("reset_hold", 3);

    // Count up by 1 for 26 edges.
    reset = 1'b0;
    steps("count_up", 26);
    check("count_up_26", int'(bus.cout), 26);

    // Preload 5 while counting, then 10 more edges.
    drive(1, 1, 1, 5, 1);
    step("preload5");
    check("preload5_val", int'(bus.cout), 5);
    drive(1, 1, 0, 5, 1);
    steps("after_pl5", 10);
    check("after_pl5_15", int'(bus.cout), 15);

    drive(1, 1, 1, 2, 1);
    step("preload2");
    check("preload2_val", int'(bus.cout), 2);
    drive(1, 1, 0, 2, 1);
    steps("after_pl2", 10);
    check("after_pl2_12", int'(bus.cout), 12);

    // Enable low holds the count.
    drive(0, 1, 0, 0, 7);
    steps("hold", 10);
    check("hold_12", int'(bus.cout), 12);

    // Re-enable with step 4.
    drive(1, 1, 0, 0, 4);
    step("incr4");
    check("incr4_16", int'(bus.cout), 16);
    step("incr4");
    check("incr4_20", int'(bus.cout), 20);
    step("incr4");
    check("incr4_24", int'(bus.cout), 24);

    // incr=0 with enable holds.
    drive(1, 1, 0, 0, 0);
    steps("incr0", 3);
    check("incr0_24", int'(bus.cout), 24);

    // Up wrap: 24 + 57*4 = 252, then 0.
    drive(1, 1, 0, 0, 4);
    steps("to252", 57);
    check("at252", int'(bus.cout), 252);
    step("up_wrap");
    check("up_wrap_0", int'(bus.cout), 0);

    // Down count and wrap from 6.
    drive(0, 0, 1, 6, 4);
    step("preload6");
    check("preload6_val", int'(bus.cout), 6);
    drive(1, 0, 0, 6, 4);
    step("down");
    check("down_2", int'(bus.cout), 2);
    step("down");
    check("down_wrap_254", int'(bus.cout), 254);
    step("down");
    check("down_250", int'(bus.cout), 250);

    // Preload outranks a decrement.
    drive(1, 0, 1, 9, 4);
    step("pl_prio");
    check("pl_prio_9", int'(bus.cout), 9);

    // Reset between edges clears without a clock edge.
    drive(1, 1, 0, 0, 3);
    step("pre_async");
    #2 reset = 1'b1;
    #1 check("async_clear", int'(bus.cout), 0);
    model = 0;
    step("async_hold");
    reset = 1'b0;
    step("after_async");
    check("after_async_3", int'(bus.cout), 3);

    // Randomized stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15),
            $urandom_range(0, 15));
      reset = ($urandom_range(0, 39) == 0);
      step("random");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
